booth4_mac_iter: RTL and testbench

- Parametrised, iterative radix-4 Booth multiply/accumulate unit. Successor to the fixed-width booth4_multiplier.
- Width is set by a parameter. Each operand has its own signedness. Adds an accumulate mode that sums the new product into the previous result.
- Sits behind a valid/ready request channel and a valid/ready result channel, for use as a shared datapath multiplier.

---
 rtl/booth4_mac_iter_pkg.sv | 35 +++
 rtl/booth4_mac_iter_if.sv | 26 ++
 rtl/booth4_mac_iter_pp_gen.sv | 27 ++
 rtl/booth4_mac_iter.sv | 119 +++++++++++
 tb/tb_booth4_mac_iter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/booth4_mac_iter_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth MAC.
// Default operand sizes carried over from the fixed-width multiplier.
package booth4_pkg;

  localparam int MUL_SIZE   = 32;
  localparam int ADDER_SIZE = 2 * MUL_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Bits are {b(2i+1), b(2i), b(2i-1)}.
  function automatic booth_digit_e booth_decode(input logic [2:0] bits);
    booth_digit_e d;
    case (bits)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth4_mac_iter_if.sv
// Request/result valid-ready channels of the Booth MAC.
// master = requester/consumer side, slave = the MAC itself.
interface booth4_mac_iter_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_op1;
  logic [WIDTH-1:0]     in_op2;
  logic                 in_op1_signed;
  logic                 in_op2_signed;
  logic                 in_acc_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_res;

  modport master (
    output in_valid, in_op1, in_op2, in_op1_signed, in_op2_signed, in_acc_en, out_ready,
    input  in_ready, out_valid, out_res
  );

  modport slave (
    input  in_valid, in_op1, in_op2, in_op1_signed, in_op2_signed, in_acc_en, out_ready,
    output in_ready, out_valid, out_res
  );
endinterface

// File: rtl/booth4_mac_iter_pp_gen.sv
// Radix-4 Booth partial product: selects 0, +-M or +-2M from the
// extended multiplicand; result is one bit wider to hold 2M.
module booth4_pp_gen
  import booth4_pkg::*;
#(
  parameter int EXT = 34
) (
  input  booth_digit_e   digit_i,
  input  logic [EXT-1:0] m_i,
  output logic [EXT:0]   pp_o
);

  logic [EXT:0] m_s;
  assign m_s = {m_i[EXT-1], m_i};

  always_comb begin
    pp_o = '0;
    case (digit_i)
      POS1:    pp_o = m_s;
      POS2:    pp_o = m_s << 1;
      NEG1:    pp_o = -m_s;
      NEG2:    pp_o = -(m_s << 1);
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth4_mac_iter.sv
// Iterative radix-4 Booth multiply/accumulate, one digit per cycle.
// Optional macro BOOTH4_EARLY_TERM_EN stops once the remaining digits are all zero.
module booth4_mac_iter
  import booth4_pkg::*;
#(
  parameter int WIDTH = MUL_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  booth4_mac_iter_if.slave bus
);

  localparam int RES_WIDTH = 2 * WIDTH;
  localparam int NDIG      = WIDTH / 2 + 1;
  localparam int EXT       = WIDTH + 2;
  localparam int PSW       = RES_WIDTH + 2;
  localparam int CW        = $clog2(NDIG);

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [RES_WIDTH-1:0] out_res_q;
  logic [RES_WIDTH-1:0] acc_q;
  logic [CW-1:0]        cnt_q;
  logic [EXT-1:0]       m_q;
  logic [EXT:0]         mq_q;     // multiplier with the bit(-1) overlap at LSB
  logic [PSW-1:0]       psum_q;
  logic [PSW-1:0]       psum_d;

  logic [EXT-1:0]       op1_ext;
  logic [EXT-1:0]       op2_ext;
  logic [PSW-1:0]       acc_ext;
  booth_digit_e         digit;
  logic [EXT:0]         pp;
  logic [PSW-1:0]       pp_wide;
  logic                 last;

  assign op1_ext = bus.in_op1_signed ? {{2{bus.in_op1[WIDTH-1]}}, bus.in_op1}
                                     : {2'b00, bus.in_op1};
  assign op2_ext = bus.in_op2_signed ? {{2{bus.in_op2[WIDTH-1]}}, bus.in_op2}
                                     : {2'b00, bus.in_op2};
  assign acc_ext = {{2{acc_q[RES_WIDTH-1]}}, acc_q};

  assign digit = booth_decode(mq_q[2:0]);

  booth4_pp_gen #(.EXT(EXT)) u_pp_gen (
    .digit_i (digit),
    .m_i     (m_q),
    .pp_o    (pp)
  );

  assign pp_wide = {{(PSW-EXT-1){pp[EXT]}}, pp};
  assign psum_d  = psum_q + (pp_wide << {cnt_q, 1'b0});

`ifdef BOOTH4_EARLY_TERM_EN
  // Remaining digits are zero when every bit still to be scanned
  // (including the next overlap bit) is identical.
  logic rest_zero;
  assign rest_zero = (&mq_q[EXT:2]) | ~(|mq_q[EXT:2]);
  assign last      = (cnt_q == CW'(NDIG-1)) | rest_zero;
`else
  assign last      = (cnt_q == CW'(NDIG-1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      m_q         <= '0;
      mq_q        <= '0;
      psum_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            m_q        <= op1_ext;
            mq_q       <= {op2_ext, 1'b0};
            psum_q     <= bus.in_acc_en ? acc_ext : '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          psum_q <= psum_d;
          mq_q   <= {{2{mq_q[EXT]}}, mq_q[EXT:2]};
          cnt_q  <= cnt_q + 1'b1;
          if (last) begin
            out_valid_q <= 1'b1;
            out_res_q   <= psum_d[RES_WIDTH-1:0];
            acc_q       <= psum_d[RES_WIDTH-1:0];
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;

endmodule

// File: tb/tb_booth4_mac_iter.sv
// Directed bench for booth4_mac_iter at WIDTH=8 (NDIG=5).
module tb_booth4_mac_iter;

  localparam int W    = 8;
  localparam int NDIG = W / 2 + 1;
`ifdef BOOTH4_EARLY_TERM_EN
  localparam int FIXED_LAT = 0;
`else
  localparam int FIXED_LAT = NDIG;
`endif

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  booth4_mac_iter_if #(.WIDTH(W)) bus ();

  booth4_mac_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. exp_lat==0 means any latency 1..NDIG.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sa, input logic sb, input logic acc,
                       input logic [2*W-1:0] exp, input int exp_lat);
    int lat;
    bit ready_seen;
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_op1 = a;
    bus.in_op2 = b;
    bus.in_op1_signed = sa;
    bus.in_op2_signed = sb;
    bus.in_acc_en = acc;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op1 = ~a;
    bus.in_op2 = ~b;
    bus.in_op1_signed = ~sa;
    bus.in_op2_signed = ~sb;
    bus.in_acc_en = ~acc;
    lat = 0;
    ready_seen = 1'b0;
    if (bus.in_ready) ready_seen = 1'b1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.in_ready) ready_seen = 1'b1;
    end
    if (exp_lat == 0) check({tag, "_lat_range"}, 32'(lat >= 1 && lat <= NDIG), 32'd1);
    else check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ready_low"}, 32'(ready_seen), 32'd0);
    check({tag, "_res"}, 32'(bus.out_res), 32'(exp));
    if (bus.out_ready) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op1 = '0;
    bus.in_op2 = '0;
    bus.in_op1_signed = 1'b0;
    bus.in_op2_signed = 1'b0;
    bus.in_acc_en = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_res", 32'(bus.out_res), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("u200x150", 8'd200, 8'd150, 1'b0, 1'b0, 1'b0, 16'h7530, FIXED_LAT);
    do_op("s_m128sq", 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 16'h4000, FIXED_LAT);
    do_op("s_m3x5", 8'hFD, 8'd5, 1'b1, 1'b1, 1'b0, 16'hFFF1, FIXED_LAT);
    do_op("u255xsm1", 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 16'hFF01, FIXED_LAT);
    do_op("sm1xu255", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 16'hFF01, FIXED_LAT);
    do_op("u10x10", 8'd10, 8'd10, 1'b0, 1'b0, 1'b0, 16'h0064, FIXED_LAT);
    do_op("acc_3xm4", 8'd3, 8'hFC, 1'b1, 1'b1, 1'b1, 16'h0058, FIXED_LAT);

    // Backpressure: result must hold while new requests knock.
    bus.out_ready = 1'b0;
    do_op("bp_7x9", 8'd7, 8'd9, 1'b0, 1'b0, 1'b0, 16'h003F, FIXED_LAT);
    bus.in_op1 = 8'd2;
    bus.in_op2 = 8'd2;
    bus.in_op1_signed = 1'b0;
    bus.in_op2_signed = 1'b0;
    bus.in_acc_en = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_res", 32'(bus.out_res), 32'h003F);
      check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    check("bp_idle_res", 32'(bus.out_res), 32'h003F);
    do_op("bp_2x2", 8'd2, 8'd2, 1'b0, 1'b0, 1'b0, 16'h0004, FIXED_LAT);

    // Reset in the middle of a calculation.
    bus.in_op1 = 8'd100;
    bus.in_op2 = 8'd100;
    bus.in_acc_en = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_res", 32'(bus.out_res), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("rst_acc_2x3", 8'd2, 8'd3, 1'b0, 1'b0, 1'b1, 16'h0006, FIXED_LAT);

`ifdef BOOTH4_EARLY_TERM_EN
    do_op("et_77x0", 8'd77, 8'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1);
    do_op("et_5xm1", 8'd5, 8'hFF, 1'b0, 1'b1, 1'b0, 16'hFFFB, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
